// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: frame-buffer RAM arbiter; the scan-out owns the port in the visible area, and queued writes drain in blanking (FB_HBLANK_WRITE_EN also permits horizontal blanking).
module vga_fb_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [9:0]                    Hcounter,
  input  logic [9:0]                    Vcounter,
  input  logic                          wr_req,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_ready,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_we,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [DATA_W-1:0]             pix_data,
  output logic                          pix_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, DISP, DRAIN} state_e;
  state_e            state_q, state_d;
  logic              visible, wr_perm, empty, push, pop;
  logic [ADDR_W-1:0] disp_addr;
  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [PW:0]       level_q;
  logic [DATA_W-1:0] pix_data_q;
  logic              pix_valid_q;
  assign visible = (Hcounter < 10'd640) && (Vcounter < 10'd480);
`ifdef FB_HBLANK_WRITE_EN
  assign wr_perm = !visible;
`else
  assign wr_perm = Vcounter >= 10'd480;
`endif
  assign disp_addr  = ADDR_W'(Vcounter[8:2]) * ADDR_W'(160) + ADDR_W'(Hcounter[9:2]);
  assign empty      = level_q == '0;
  assign wr_ready   = level_q != (PW+1)'(FIFO_DEPTH);
  assign push       = wr_req && wr_ready;
  assign fifo_level = level_q;
  assign pix_data   = pix_data_q;
  assign pix_valid  = pix_valid_q;
  // Decided from this cycle's scan position so the display is never stalled and a drain stops the very cycle the visible area begins.
  always_comb begin
    state_d   = visible ? DISP : (wr_perm && !empty && !rst) ? DRAIN : IDLE;
    pop       = state_d == DRAIN;
    mem_we    = pop;
    mem_addr  = pop ? addr_mem[rd_ptr_q] : disp_addr;
    mem_wdata = data_mem[rd_ptr_q];
  end
  // state_q == DISP doubles as the first visible-flag delay stage, aligned with the RAM read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      wr_ptr_q    <= push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      level_q     <= level_q + (PW+1)'(push) - (PW+1)'(pop);
      pix_valid_q <= state_q == DISP;
      pix_data_q  <= (state_q == DISP) ? mem_rdata : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= wr_addr;
      data_mem[wr_ptr_q] <= wr_data;
    end
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: scenario tasks plus a scoreboard of expected RAM writes and pixel outputs for vga_fb_arbiter (honours FB_HBLANK_WRITE_EN).
module tb_vga_fb_arbiter;
  localparam int AW = 15, DW = 8, D = 4;
  logic          clk = 0, rst = 1;
  logic [9:0]    hc = 0, vc = 0;
  logic          wr_req = 0;
  logic [AW-1:0] wr_addr = 0;
  logic [DW-1:0] wr_data = 0;
  logic          wr_ready, mem_we, pix_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, pix_data;
  logic [DW-1:0] mem_rdata = 0;
  logic [2:0]    fifo_level;
  int total = 0, bad = 0, lvl_m = 0;
  logic [AW+DW-1:0] wq [$];
  logic [DW:0]      pq [$];
  logic m_vis, m_perm, m_drain, m_acc;
  logic [AW+DW-1:0] we_exp;
  logic [DW:0]      pe;
  always #5 clk = ~clk;
  vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .Hcounter(hc), .Vcounter(vc),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .fifo_level(fifo_level)
  );
  function automatic logic [DW-1:0] rf(input logic [AW-1:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h3C;
  endfunction
  function automatic logic [AW-1:0] dm(input logic [9:0] h, input logic [9:0] v);
    logic [31:0] t;
    t = v[8:2] * 160 + h[9:2];
    return t[AW-1:0];
  endfunction
  always @(posedge clk) mem_rdata <= rf(mem_addr);
  // Reference model and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      lvl_m = 0;
      wq.delete();
      pq.delete();
    end else begin
      m_vis = (hc < 640) && (vc < 480);
`ifdef FB_HBLANK_WRITE_EN
      m_perm = !m_vis;
`else
      m_perm = vc >= 480;
`endif
      m_drain = !m_vis && m_perm && (lvl_m > 0);
      m_acc = wr_req && (lvl_m < D);
      total++; if (fifo_level !== 3'(lvl_m)) begin bad++; $display("FAIL mon_level got=%0d exp=%0d", fifo_level, lvl_m); end
      total++; if (wr_ready !== logic'(lvl_m < D)) begin bad++; $display("FAIL mon_ready got=%b exp=%b", wr_ready, lvl_m < D); end
      total++; if (mem_we !== m_drain) begin bad++; $display("FAIL mon_we h=%0d v=%0d got=%b exp=%b", hc, vc, mem_we, m_drain); end
      if (m_drain) begin
        we_exp = wq.pop_front();
        total++; if ({mem_addr, mem_wdata} !== we_exp) begin bad++; $display("FAIL mon_write got=%h/%h exp=%h/%h", mem_addr, mem_wdata, we_exp[AW+DW-1:DW], we_exp[DW-1:0]); end
      end else begin
        total++; if (mem_addr !== dm(hc, vc)) begin bad++; $display("FAIL mon_disp_addr got=%0d exp=%0d", mem_addr, dm(hc, vc)); end
      end
      if (m_acc) wq.push_back({wr_addr, wr_data});
      lvl_m = lvl_m + int'(m_acc) - int'(m_drain);
      if (pq.size() >= 2) begin
        pe = pq.pop_front();
        total++; if ({pix_valid, pix_data} !== pe) begin bad++; $display("FAIL mon_pix got=%b/%h exp=%b/%h", pix_valid, pix_data, pe[DW], pe[DW-1:0]); end
      end
      pq.push_back({m_vis, m_vis ? rf(dm(hc, vc)) : 8'h00});
    end
  end
  task automatic step(input int h, input int v, input logic r, input int a, input int d);
    @(posedge clk); #1;
    hc = 10'(h); vc = 10'(v);
    wr_req = r; wr_addr = AW'(a); wr_data = DW'(d);
    #1;
  endtask
  task automatic test_reset;
    rst = 1; #2;
    total++; if ({mem_we, pix_valid, pix_data, fifo_level, wr_ready} !== {1'b0, 1'b0, 8'h00, 3'd0, 1'b1}) begin bad++; $display("FAIL reset_state got=%b exp=%b", {mem_we, pix_valid, pix_data, fifo_level, wr_ready}, 14'b1); end
    @(posedge clk); #1; rst = 0; hc = 0; vc = 0; #1;
    for (int h = 0; h < 8; h++) begin
      if (h > 0) step(h, 0, 0, 0, 0);
      total++; if (mem_addr !== AW'(h / 4)) begin bad++; $display("FAIL reset_addr h=%0d got=%0d exp=%0d", h, mem_addr, h / 4); end
      total++; if (pix_valid !== logic'(h >= 2)) begin bad++; $display("FAIL reset_pix_valid h=%0d got=%b exp=%b", h, pix_valid, h >= 2); end
    end
    step(0, 4, 0, 0, 0);
    total++; if (mem_addr !== AW'(160)) begin bad++; $display("FAIL reset_addr_v4 got=%0d exp=160", mem_addr); end
  endtask
  task automatic test_fill_drain;
    for (int i = 0; i < 4; i++) step(i, 100, 1, 5 + i, 'hA1 + i);
    step(4, 100, 1, 9, 'hA5);
    total++; if ({wr_ready, fifo_level} !== {1'b0, 3'd4}) begin bad++; $display("FAIL fill_full got=%b/%0d exp=0/4", wr_ready, fifo_level); end
    step(5, 100, 1, 9, 'hA5);
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL fill_ignored got=%0d exp=4", fifo_level); end
    step(6, 100, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(i, 480, 0, 0, 0);
      total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, AW'(5 + i), DW'('hA1 + i)}) begin bad++; $display("FAIL fill_drain%0d got=%b/%0d/%h exp=1/%0d/%h", i, mem_we, mem_addr, mem_wdata, 5 + i, 'hA1 + i); end
    end
    step(4, 480, 0, 0, 0);
    total++; if ({mem_we, fifo_level} !== {1'b0, 3'd0}) begin bad++; $display("FAIL fill_empty got=%b/%0d exp=0/0", mem_we, fifo_level); end
  endtask
  task automatic test_hblank;
    step(600, 10, 1, 50, 'h11);
    step(601, 10, 1, 51, 'h22);
    for (int h = 602; h < 640; h++) step(h, 10, 0, 0, 0);
`ifdef FB_HBLANK_WRITE_EN
    for (int i = 0; i < 2; i++) begin
      step(640 + i, 10, 0, 0, 0);
      total++; if ({mem_we, mem_addr} !== {1'b1, AW'(50 + i)}) begin bad++; $display("FAIL hblank_write%0d got=%b/%0d exp=1/%0d", i, mem_we, mem_addr, 50 + i); end
    end
    step(642, 10, 0, 0, 0);
    total++; if ({mem_we, fifo_level} !== {1'b0, 3'd0}) begin bad++; $display("FAIL hblank_done got=%b/%0d exp=0/0", mem_we, fifo_level); end
`else
    for (int h = 640; h < 650; h++) begin
      step(h, 10, 0, 0, 0);
      total++; if ({mem_we, fifo_level} !== {1'b0, 3'd2}) begin bad++; $display("FAIL hblank_held h=%0d got=%b/%0d exp=0/2", h, mem_we, fifo_level); end
    end
    for (int i = 0; i < 2; i++) begin
      step(i, 480, 0, 0, 0);
      total++; if ({mem_we, mem_addr} !== {1'b1, AW'(50 + i)}) begin bad++; $display("FAIL hblank_vwrite%0d got=%b/%0d exp=1/%0d", i, mem_we, mem_addr, 50 + i); end
    end
    step(2, 480, 0, 0, 0);
`endif
  endtask
  task automatic test_push_pop;
    step(0, 200, 1, 20, 'h31);
    step(1, 200, 1, 21, 'h32);
    step(0, 480, 1, 22, 'h33);
    total++; if ({mem_we, mem_addr, fifo_level} !== {1'b1, AW'(20), 3'd2}) begin bad++; $display("FAIL pushpop_head got=%b/%0d/%0d exp=1/20/2", mem_we, mem_addr, fifo_level); end
    step(1, 480, 0, 0, 0);
    total++; if ({mem_addr, fifo_level} !== {AW'(21), 3'd2}) begin bad++; $display("FAIL pushpop_level got=%0d/%0d exp=21/2", mem_addr, fifo_level); end
    step(2, 480, 0, 0, 0);
    step(3, 480, 0, 0, 0);
    total++; if ({mem_we, fifo_level} !== {1'b0, 3'd0}) begin bad++; $display("FAIL pushpop_empty got=%b/%0d exp=0/0", mem_we, fifo_level); end
  endtask
  task automatic test_mid_drain;
    for (int i = 0; i < 3; i++) step(i, 300, 1, 30 + i, 'h40 + i);
    step(3, 300, 0, 0, 0);
    step(0, 480, 0, 0, 0);
    total++; if ({mem_we, mem_addr} !== {1'b1, AW'(30)}) begin bad++; $display("FAIL mid_first got=%b/%0d exp=1/30", mem_we, mem_addr); end
    step(0, 0, 0, 0, 0);
    total++; if ({mem_we, mem_addr, fifo_level} !== {1'b0, AW'(0), 3'd2}) begin bad++; $display("FAIL mid_stop got=%b/%0d/%0d exp=0/0/2", mem_we, mem_addr, fifo_level); end
    step(4, 0, 0, 0, 0);
    total++; if ({mem_we, fifo_level} !== {1'b0, 3'd2}) begin bad++; $display("FAIL mid_retain got=%b/%0d exp=0/2", mem_we, fifo_level); end
    for (int h = 0; h < 3; h++) step(h, 480, 0, 0, 0);
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL mid_finish got=%0d exp=0", fifo_level); end
  endtask
  task automatic test_reset_drain;
    for (int i = 0; i < 3; i++) step(i, 300, 1, 40 + i, 'h50 + i);
    step(3, 300, 0, 0, 0);
    step(0, 480, 0, 0, 0);
    total++; if ({mem_we, mem_addr} !== {1'b1, AW'(40)}) begin bad++; $display("FAIL rstd_first got=%b/%0d exp=1/40", mem_we, mem_addr); end
    @(posedge clk); #1; hc = 10'd1; rst = 1; #1;
    total++; if ({mem_we, fifo_level, wr_ready} !== {1'b0, 3'd0, 1'b1}) begin bad++; $display("FAIL rstd_clear got=%b/%0d/%b exp=0/0/1", mem_we, fifo_level, wr_ready); end
    step(2, 480, 0, 0, 0);
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rstd_held got=%b exp=0", mem_we); end
    step(3, 480, 0, 0, 0);
    rst = 0;
    for (int h = 4; h < 8; h++) begin
      step(h, 480, 0, 0, 0);
      total++; if ({mem_we, fifo_level} !== {1'b0, 3'd0}) begin bad++; $display("FAIL rstd_stale h=%0d got=%b/%0d exp=0/0", h, mem_we, fifo_level); end
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    test_reset;
    test_fill_drain;
    test_hblank;
    test_push_pop;
    test_mid_drain;
    test_reset_drain;
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15: frame-buffer word address width, covering 160x120 = 19200 words.
REQ-002 Parameter DATA_W, default 8: pixel word width.
REQ-003 Parameter FIFO_DEPTH, default 4: write-FIFO entries; SHALL be a power of two, minimum 2.
REQ-004 Port clk, input, 1: single clock, the 25 MHz pixel clock; all logic is rising-edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port Hcounter, input, 10: horizontal scan position from the VGA timing chain.
REQ-007 Port Vcounter, input, 10: vertical scan position from the VGA timing chain.
REQ-008 Port wr_req, input, 1: writer presents a pixel write.
REQ-009 Port wr_addr, input, ADDR_W: write address.
REQ-010 Port wr_data, input, DATA_W: write data.
REQ-011 Port wr_ready, output, 1: FIFO can accept a write.
REQ-012 Port mem_addr, output, ADDR_W: address to the single-port frame-buffer RAM.
REQ-013 Port mem_we, output, 1: RAM write enable.
REQ-014 Port mem_wdata, output, DATA_W: RAM write data.
REQ-015 Port mem_rdata, input, DATA_W: RAM read data, valid one cycle after mem_addr.
REQ-016 Port pix_data, output, DATA_W: pixel data toward the colour stage.
REQ-017 Port pix_valid, output, 1: pix_data belongs to the visible area.
REQ-018 Port fifo_level, output, log2(FIFO_DEPTH)+1: number of occupied FIFO entries.

Function
REQ-019 Visible area SHALL be Hcounter<640 AND Vcounter<480, evaluated combinationally each cycle; all other positions are blanking.
REQ-020 Display address SHALL be Vcounter[8:2]*160 + Hcounter[9:2], computed modulo 2^ADDR_W.
REQ-021 States:
- DISP: visible area; RAM port owned by display.
- DRAIN: blanking, write permitted, FIFO non-empty.
- IDLE: otherwise.
REQ-022 State is registered; the next state SHALL be chosen each cycle from the current-cycle visible flag, write permission and FIFO empty.
REQ-023 In DISP, mem_addr = display address and mem_we = 0; display SHALL never be stalled.
REQ-024 In DRAIN, mem_addr/mem_wdata SHALL equal the FIFO head and mem_we = 1, popping one entry per cycle.
REQ-025 In IDLE, mem_we = 0 and mem_addr = display address.
REQ-026 pix_data SHALL register mem_rdata.
REQ-027 pix_valid SHALL be the visible flag delayed two cycles, matching the RAM read latency plus the output register; pix_data = 0 whenever pix_valid = 0.
REQ-028 A write is accepted on a cycle where wr_req AND wr_ready; wr_ready = (fifo_level < FIFO_DEPTH).
REQ-029 wr_req while full SHALL be ignored with no side effect; the writer holds request and data until accepted.
REQ-030 Simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-031 A push into an empty FIFO SHALL reach the RAM no earlier than the following cycle.
REQ-032 Writes SHALL be issued in acceptance order.
REQ-033 Entering the visible area mid-drain SHALL stop the drain that cycle; remaining entries are retained.

Reset
REQ-034 Assertion of rst SHALL immediately clear the following: state to IDLE, fifo_level 0, FIFO pointers 0, mem_we 0, pix_data 0, pix_valid 0, and both delay stages; mem_addr then follows the display address.
REQ-035 Reset asserted during DRAIN SHALL discard pending entries, and no RAM write SHALL occur while rst is high.

Configuration
REQ-036 Macro FB_HBLANK_WRITE_EN:
- Defined: write permission = any blanking, horizontal or vertical.
- Undefined: write permission = Vcounter>=480 only, and DRAIN is never entered during horizontal blanking of visible lines.

Verification
REQ-037 Release reset at H=0, V=0 with no writes -> mem_we stays 0, mem_addr=0 at H=0..3, 1 at H=4, 160 at V=4 H=0; pix_valid rises 2 cycles after H=0.
REQ-038 Push 4 writes (addr 5..8, data 0xA1..0xA4) during visible area -> wr_ready=0 after the 4th; 5th request is ignored; at V=480 the 4 RAM writes occur in order on 4 consecutive cycles; fifo_level reaches 0.
REQ-039 With FB_HBLANK_WRITE_EN defined, push 2 writes at V=10 H=600 -> both written at H=640,641; with the macro undefined -> writes are held until V=480.
REQ-040 Push and drain in the same cycle at fifo_level=2 -> fifo_level stays 2; the written address equals the oldest entry.
REQ-041 FIFO holding 3 entries, with the visible area starting after the 1st pop -> exactly 1 write occurs, fifo_level=2, and mem_addr returns to the display address the same cycle.
REQ-042 Assert rst in DRAIN with 3 entries -> mem_we=0 immediately, fifo_level=0, wr_ready=1; no stale write after release.
